vc_pipe_sink: RTL
=================

# vc_pipe_sink

Tail-end receiver for the pipeline val/stall/squash protocol. It accepts the `next_val`/message leaving the last pipeline stage and drives that stage's `next_stall` and `next_squash` inputs. Internally it holds a 2-entry skid buffer and presents the result on a val/rdy output port to a decoupled consumer such as a memory or network interface. Because the stall is derived only from registered state, there is no combinational path from `in_val` or `out_rdy` to `in_stall`.

## Interface
- `NBITS`, default 32, message width in bits.
- `clk`  input  1  clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous reset, active-low.
- `in_val`  input  1  valid from the last stage (that stage's `next_val`).
- `in_msg`  input  NBITS  message accompanying `in_val`.
- `in_stall`  output  1  connects to the last stage's `next_stall`.
- `in_squash`  output  1  connects to the last stage's `next_squash`.
- `flush`  input  1  consumer-side flush request; exists only with `VC_PIPE_SINK_SQUASH_EN`.
- `out_val`  output  1  head entry valid.
- `out_rdy`  input  1  consumer ready.
- `out_msg`  output  NBITS  head entry data.
- `count`  output  2  occupancy, 0 to 2.
- `err`  output  1  sticky protocol-violation flag.

## Operation
- FSM states:
  - EMPTY (count 0).
  - ONE (count 1).
  - FULL (count 2).
- Handshake definitions:
  - `enq = in_val && !in_stall && !flush_eff`.
  - `deq = out_val && out_rdy`.
- Transitions:
  - EMPTY→ONE on `enq`.
  - ONE→FULL on `enq && !deq`.
  - ONE→EMPTY on `deq && !enq`.
  - ONE stays ONE on `enq && deq`; the head advances to the new entry.
  - FULL→ONE on `deq`.
- Output equations:
  - `in_stall = (state == FULL)`, purely registered.
  - `out_val = (state != EMPTY)`.
  - `out_msg` = entry at the head pointer.
- Storage: two NBITS entries plus 1-bit head and tail pointers. Pointers wrap modulo 2, and `count` equals the state encoding.
- Protocol violation: `in_val && in_stall` in the same cycle.
  - The message is discarded and `err` sets.
  - `err` clears only on reset.
  - The upstream stage gates `next_val` with `next_stall`, so this case must never occur in a correct system.
- `in_squash` is driven by `flush_eff` (see Configuration).

## Timing
- Reset values: `in_stall` 0, `in_squash` 0, `out_val` 0, `out_msg` 0, `count` 0, `err` 0, both pointers 0.
- Latency: `enq` in cycle t gives `out_val` = 1 in cycle t+1. There is no same-cycle bypass.
- Throughput: one message per cycle while `out_rdy` stays high; in that case `in_stall` never asserts.
- `in_stall` asserts in the cycle after the second entry is captured with no dequeue. It deasserts in the cycle after the first `deq` from FULL.
- `out_msg` is stable while `out_val && !out_rdy`. Order is strict FIFO.
- Reset asserted mid-operation empties the buffer immediately (asynchronous). Buffered messages are lost and no `out_val` follows.
- Flush in cycle t, when enabled:
  - `in_squash` = 1 combinationally in cycle t.
  - A `deq` in cycle t still completes.
  - Any `in_val` in cycle t is dropped.
  - `count` = 0 at t+1.

## Configuration
- `VC_PIPE_SINK_SQUASH_EN` defined:
  - The `flush` port exists and `flush_eff = flush`.
  - `in_squash = flush`, so the upstream pipeline discards its in-flight instruction.
  - The buffer clears at the next edge.
- `VC_PIPE_SINK_SQUASH_EN` undefined:
  - The `flush` port is absent and `flush_eff = 0`.
  - `in_squash` is tied to 0.
  - The FSM has no flush transitions.

## Structure
- The shared header `vc-pipe-defs.v` is the package. It holds:
  - state encodings `VC_PIPE_SINK_EMPTY` = 0, `VC_PIPE_SINK_ONE` = 1, `VC_PIPE_SINK_FULL` = 2;
  - the depth constant 2.
- Sub-module `vc_PipeSinkCtrl`:
  - contents: FSM, pointers, `err`, and the `enq`/`deq`/stall/squash equations;
  - outputs: write enables and head select to the datapath.
- The top level instantiates the control plus two `vc_EnResetReg` entries and a 2:1 output mux.

## Test plan
- Reset low, then high; `out_rdy` = 1; `in_val` = 1 for 4 cycles with msgs 0xA0–0xA3 → `out_val` from cycle 1, msgs emerge in order one per cycle, `in_stall` stays 0, `count` ≤ 1.
- `out_rdy` = 0; send 0x11, then 0x22 → `count` = 2 and `in_stall` = 1 from the next cycle. Raise `out_rdy` → 0x11 then 0x22 out; `in_stall` drops the cycle after the first `deq`.
- FULL with `in_val` = 1 held by the bench (violation) → msg not stored, `count` stays 2, `err` = 1 and stays 1 until reset.
- ONE state, `enq` 0x33 and `deq` in the same cycle → `count` stays 1, next `out_msg` = 0x33.
- With `VC_PIPE_SINK_SQUASH_EN`: FULL, then `flush` = 1 for one cycle with `in_val` = 1 and `out_rdy` = 0 → `in_squash` = 1 that cycle, input dropped, `count` = 0 and `out_val` = 0 the next cycle. Without the macro, `in_squash` is constantly 0.
- Assert reset mid-stream at `count` = 2 → `count` = 0, `out_val` = 0, `in_stall` = 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/vc_pipe_sink_pkg.sv
// vc_pipe_sink_pkg: shared definitions for the pipeline tail-end sink.
// Holds the buffer depth and the state encoding, which doubles as the
// occupancy count.
package vc_pipe_sink_pkg;

  localparam int DEPTH = 2;

  typedef enum logic [1:0] {
    VC_PIPE_SINK_EMPTY = 2'd0,
    VC_PIPE_SINK_ONE   = 2'd1,
    VC_PIPE_SINK_FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/vc_pipe_sink_if.sv
// vc_pipe_sink_if: groups the upstream val/stall/squash signals and the
// downstream val/rdy signals of the sink. The master drives messages in
// and consumes them; the slave is the sink itself.
// Optional macro VC_PIPE_SINK_SQUASH_EN adds the flush request.
interface vc_pipe_sink_if #(
  parameter int NBITS = 32
);

  logic             in_val;
  logic [NBITS-1:0] in_msg;
  logic             in_stall;
  logic             in_squash;
`ifdef VC_PIPE_SINK_SQUASH_EN
  logic             flush;
`endif
  logic             out_val;
  logic             out_rdy;
  logic [NBITS-1:0] out_msg;

  modport master (
    output in_val, in_msg, out_rdy,
`ifdef VC_PIPE_SINK_SQUASH_EN
    output flush,
`endif
    input  in_stall, in_squash, out_val, out_msg
  );

  modport slave (
    input  in_val, in_msg, out_rdy,
`ifdef VC_PIPE_SINK_SQUASH_EN
    input  flush,
`endif
    output in_stall, in_squash, out_val, out_msg
  );

endinterface

// File: rtl/vc_pipe_sink_ctrl.sv
// vc_PipeSinkCtrl: control for the 2-entry skid buffer. Owns the occupancy
// FSM, the head/tail pointers and the sticky error flag, and tells the
// datapath which entry to write and which to present.
// Optional macro VC_PIPE_SINK_SQUASH_EN adds the flush input.
module vc_PipeSinkCtrl
  import vc_pipe_sink_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             in_val,
  input  logic             out_rdy,
`ifdef VC_PIPE_SINK_SQUASH_EN
  input  logic             flush,
`endif
  output logic             in_stall,
  output logic             in_squash,
  output logic             out_val,
  output logic [1:0]       count,
  output logic             err,
  output logic [DEPTH-1:0] wr_en,
  output logic             head_sel
);

  localparam int PTR_W = $clog2(DEPTH);

  state_t           state, state_next;
  logic [PTR_W-1:0] head_ptr, head_next;
  logic [PTR_W-1:0] tail_ptr, tail_next;
  logic             flush_eff;
  logic             enq;
  logic             deq;

`ifdef VC_PIPE_SINK_SQUASH_EN
  assign flush_eff = flush;
`else
  assign flush_eff = 1'b0;
`endif

  // Stall comes only from registered state so no input reaches it combinationally.
  assign in_stall  = (state == VC_PIPE_SINK_FULL);
  assign in_squash = flush_eff;
  assign out_val   = (state != VC_PIPE_SINK_EMPTY);
  assign count     = state;
  assign head_sel  = head_ptr;
  assign enq       = in_val && !in_stall && !flush_eff;
  assign deq       = out_val && out_rdy;

  // State, pointers and the sticky violation flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= VC_PIPE_SINK_EMPTY;
      head_ptr <= '0;
      tail_ptr <= '0;
      err      <= 1'b0;
    end else begin
      state    <= state_next;
      head_ptr <= head_next;
      tail_ptr <= tail_next;
      if (in_val && in_stall) begin
        err <= 1'b1;
      end
    end
  end

  // Next occupancy and pointer advance; a flush wins over everything else.
  always_comb begin
    state_next = state;
    head_next  = head_ptr;
    tail_next  = tail_ptr;
    if (enq) begin
      tail_next = tail_ptr + 1'b1;
    end
    if (deq) begin
      head_next = head_ptr + 1'b1;
    end
    case (state)
      VC_PIPE_SINK_EMPTY: if (enq) state_next = VC_PIPE_SINK_ONE;
      VC_PIPE_SINK_ONE: begin
        if (enq && !deq) begin
          state_next = VC_PIPE_SINK_FULL;
        end else if (deq && !enq) begin
          state_next = VC_PIPE_SINK_EMPTY;
        end
      end
      VC_PIPE_SINK_FULL: if (deq) state_next = VC_PIPE_SINK_ONE;
      default: state_next = VC_PIPE_SINK_EMPTY;
    endcase
`ifdef VC_PIPE_SINK_SQUASH_EN
    if (flush_eff) begin
      state_next = VC_PIPE_SINK_EMPTY;
      head_next  = '0;
      tail_next  = '0;
    end
`endif
  end

  // Steer the enqueued message into the entry at the tail pointer.
  always_comb begin
    wr_en = '0;
    if (enq) begin
      wr_en[tail_ptr] = 1'b1;
    end
  end

endmodule

// File: rtl/vc_pipe_sink_reg.sv
// vc_EnResetReg: enabled data register that clears to zero on the
// asynchronous active-low reset.
module vc_EnResetReg #(
  parameter int NBITS = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [NBITS-1:0] d,
  output logic [NBITS-1:0] q
);

  // Capture d only when enabled; hold otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/vc_pipe_sink.sv
// vc_pipe_sink: tail-end receiver for the val/stall/squash pipeline. Buffers
// up to two messages and presents them on a val/rdy port in FIFO order.
// Optional macro VC_PIPE_SINK_SQUASH_EN enables the consumer flush/squash.
module vc_pipe_sink
  import vc_pipe_sink_pkg::*;
#(
  parameter int NBITS = 32
) (
  input  logic          clk,
  input  logic          reset,
  vc_pipe_sink_if.slave pipe,
  output logic [1:0]    count,
  output logic          err
);

  logic [DEPTH-1:0] wr_en;
  logic             head_sel;
  logic [NBITS-1:0] entry_q [DEPTH];

  vc_PipeSinkCtrl ctrl (
    .clk       (clk),
    .reset     (reset),
    .in_val    (pipe.in_val),
    .out_rdy   (pipe.out_rdy),
`ifdef VC_PIPE_SINK_SQUASH_EN
    .flush     (pipe.flush),
`endif
    .in_stall  (pipe.in_stall),
    .in_squash (pipe.in_squash),
    .out_val   (pipe.out_val),
    .count     (count),
    .err       (err),
    .wr_en     (wr_en),
    .head_sel  (head_sel)
  );

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    vc_EnResetReg #(.NBITS(NBITS)) entry (
      .clk   (clk),
      .reset (reset),
      .en    (wr_en[i]),
      .d     (pipe.in_msg),
      .q     (entry_q[i])
    );
  end

  assign pipe.out_msg = entry_q[head_sel];

endmodule
